sse_feeder: RTL and testbench
=============================

SSE_FEEDER -- requirements
Module: sse_feeder

Interface
REQ-001 Parameter DEPTH, default 16, pair-FIFO depth in entries (power of two, 2..256).
REQ-002 Parameter AW, default 4, log2(DEPTH).
REQ-003 clk  input  1  single clock; all logic updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 wr_en  input  1  write strobe; pushes one {wr_a, wr_b} pair.
REQ-006 wr_a  input  32  reference sample, IEEE-754 single.
REQ-007 wr_b  input  32  filter-output sample, IEEE-754 single.
REQ-008 start  input  1  one-cycle frame-start pulse.
REQ-009 frame_len  input  AW+1  number of pairs in the frame, 1..DEPTH; sampled with start.
REQ-010 next  input  1  consumer strobe: current A/B pair taken, present the next pair.
REQ-011 A  output  32  minuend operand to the SSE stage.
REQ-012 B  output  32  subtrahend operand to the SSE stage.
REQ-013 stop  output  1  high while the presented pair is the last of the frame.
REQ-014 valid  output  1  A/B hold a frame pair.
REQ-015 done  output  1  frame fully consumed.
REQ-016 full, empty  output  1 each  FIFO status.
REQ-017 level  output  AW+1  FIFO occupancy, 0..DEPTH.
REQ-018 overflow, underrun  output  1 each  sticky error flags.

Function
REQ-019 FIFO: circular buffer, AW-bit read/write pointers wrapping DEPTH-1 -> 0; level counts 0..DEPTH.
REQ-020 Push when wr_en and not full; wr_en while full drops the pair, sets overflow, and leaves level unchanged.
REQ-021 Simultaneous push and pop leave level unchanged; push while full is accepted if a pop occurs in the same cycle.
REQ-022 Rising-edge detect on next (next & ~next_q); a level held high counts once.
REQ-023 States: IDLE, PRIME, STREAM, DONE.
REQ-024 IDLE: start with frame_len in 1..DEPTH latches remaining = frame_len and goes to PRIME; start with frame_len = 0 or > DEPTH is ignored.
REQ-025 PRIME: when not empty, pop head into A/B, remaining -= 1, valid = 1, go STREAM; when empty, wait with valid = 0.
REQ-026 STREAM, next edge, remaining > 0, FIFO not empty: pop into A/B, remaining -= 1 on that same edge; the new pair is visible the following cycle.
REQ-027 STREAM, next edge, remaining > 0, FIFO empty: set underrun, set pending, and hold A/B; the first push then pops without a further next edge.
REQ-028 STREAM, next edge, remaining = 0: go DONE; A/B hold the last pair.
REQ-029 stop = valid and (remaining = 0) in STREAM; stop = 1 in DONE.
REQ-030 DONE: done = 1 and valid = 1; next edges are ignored.
REQ-031 DONE, start with a legal frame_len: clear done and stop, latch remaining, go PRIME.
REQ-032 start in PRIME or STREAM is ignored; frames are never truncated.
REQ-033 Writes are accepted in every state; FIFO contents persist across frames.
REQ-034 No arithmetic on sample data; the 32-bit words pass bit-exact.

Reset
REQ-035 rst overrides all other inputs, including mid-frame.
REQ-036 rst values: state IDLE, pointers 0, level 0, empty 1, full 0, A = 0, B = 0, valid 0, stop 0, done 0, overflow 0, underrun 0, pending 0, next_q 0.
REQ-037 FIFO contents are discarded by reset; no pair written before reset is ever presented.

Verification
REQ-038 Push pairs (1.0,0.5), (2.0,1.0), (3.0,3.0); start with frame_len = 3; three next pulses -> A/B show each pair in order; stop rises with (3.0,3.0); DONE is reached on the third next.
REQ-039 Push 16 pairs -> full = 1, level = 16; a 17th wr_en -> overflow = 1, level = 16; push and pop in the same cycle -> level stays 16.
REQ-040 start with frame_len = 2 and an empty FIFO -> valid = 0 in PRIME; push (4.0,1.0) -> A = 0x40800000, B = 0x3F800000 next cycle; next with the FIFO empty -> underrun = 1; a later push presents the pair with no further next.
REQ-041 Hold next high for 5 cycles -> exactly one pop; frame_len = 0 on start -> stays IDLE.
REQ-042 rst asserted mid-STREAM with level = 5 -> next cycle: IDLE, level = 0, A = 0, valid = 0, stop = 0, flags cleared.
REQ-043 Run 20 pairs through wrap-around with frame_len = 16 -> data is bit-exact in order; a restart from DONE with frame_len = 4 consumes the remaining 4.

Source files
------------

// File: rtl/sse_feeder_if.sv
// sse_feeder_if -- bundle of all non-clock signals of the SSE operand feeder.
//   Producer side : wr_en, wr_a, wr_b (pair writes into the FIFO)
//   Control side  : start, frame_len (frame request), next (consumer strobe)
//   Operand side  : A, B, stop, valid, done (pair presented to the SSE stage)
//   Status side   : full, empty, level, overflow, underrun
// Modports:
//   master -- drives writes/control, observes operands/status (the environment)
//   slave  -- the feeder itself
// AW must match the AW of the sse_feeder instance it is bound to.
interface sse_feeder_if #(
  parameter int AW = 4
);
  logic          wr_en;
  logic [31:0]   wr_a;
  logic [31:0]   wr_b;
  logic          start;
  logic [AW:0]   frame_len;
  logic          next;
  logic [31:0]   A;
  logic [31:0]   B;
  logic          stop;
  logic          valid;
  logic          done;
  logic          full;
  logic          empty;
  logic [AW:0]   level;
  logic          overflow;
  logic          underrun;

  modport master (
    output wr_en, wr_a, wr_b, start, frame_len, next,
    input  A, B, stop, valid, done, full, empty, level, overflow, underrun
  );

  modport slave (
    input  wr_en, wr_a, wr_b, start, frame_len, next,
    output A, B, stop, valid, done, full, empty, level, overflow, underrun
  );
endinterface

// File: rtl/sse_feeder.sv
// sse_feeder -- buffers {reference, filter-output} sample pairs in a circular
// FIFO and presents them, one frame at a time, as A/B operands to a
// sum-of-squared-errors stage. Sample words pass through bit-exact.
// Ports:
//   clk  -- single clock, everything updates on its rising edge
//   rst  -- synchronous active-high reset, overrides every other input
//   bus  -- sse_feeder_if.slave: pair writes, frame start/length, consumer
//           next strobe, A/B operands with stop/valid/done, FIFO status and
//           sticky overflow/underrun flags
// Parameters:
//   DEPTH -- FIFO depth in pairs (power of two, 2..256)
//   AW    -- log2(DEPTH)
module sse_feeder #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic        clk,
  input  logic        rst,
  sse_feeder_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRIME  = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [AW:0]   DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW:0]   ZERO_L  = '0;
  localparam logic [AW:0]   ONE_L   = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  state_t        state_reg, state_next;

  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   level_reg;
  logic [AW:0]   remaining_reg;
  logic [31:0]   a_reg;
  logic [31:0]   b_reg;
  logic          overflow_reg;
  logic          underrun_reg;
  logic          pending_reg;
  logic          next_q_reg;

  logic          full;
  logic          empty;
  logic          next_edge;
  logic          len_ok;
  logic          rem_zero;
  logic          start_ok;
  logic          pop;
  logic          push;
  logic          underrun_evt;

  assign full      = (level_reg == DEPTH_L);
  assign empty     = (level_reg == ZERO_L);
  assign next_edge = bus.next & ~next_q_reg;
  assign len_ok    = (bus.frame_len != ZERO_L) && (bus.frame_len <= DEPTH_L);
  assign rem_zero  = (remaining_reg == ZERO_L);

  // A frame can only be launched from IDLE or DONE, so running frames are
  // never truncated by a stray start.
  assign start_ok  = bus.start && len_ok &&
                     ((state_reg == IDLE) || (state_reg == DONE));

  // A pending fetch (next arrived while the FIFO was empty) completes on the
  // first cycle data is available, with no further next edge required.
  assign pop = !empty &&
               ((state_reg == PRIME) ||
                ((state_reg == STREAM) && !rem_zero && (pending_reg || next_edge)));

  // The pop decision does not depend on wr_en, so a push into a full FIFO
  // can be accepted in the same cycle as a pop without a combinational loop.
  assign push = bus.wr_en && (!full || pop);

  assign underrun_evt = (state_reg == STREAM) && next_edge && !pending_reg &&
                        !rem_zero && empty;

  // Storage: no reset so it maps onto block RAM; reset discards contents by
  // clearing the pointers and level instead.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem[wr_ptr_reg] <= {bus.wr_a, bus.wr_b};
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start_ok) state_next = PRIME;
      PRIME:   if (!empty) state_next = STREAM;
      STREAM:  if (next_edge && !pending_reg && rem_zero) state_next = DONE;
      DONE:    if (start_ok) state_next = PRIME;
      default: state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bus.valid = 1'b0;
    bus.stop  = 1'b0;
    bus.done  = 1'b0;
    case (state_reg)
      STREAM: begin
        bus.valid = 1'b1;
        bus.stop  = rem_zero;
      end
      DONE: begin
        bus.valid = 1'b1;
        bus.stop  = 1'b1;
        bus.done  = 1'b1;
      end
      default: ;
    endcase
  end

  // FIFO pointers, occupancy, operand registers and frame bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      level_reg     <= '0;
      remaining_reg <= '0;
      a_reg         <= '0;
      b_reg         <= '0;
      overflow_reg  <= 1'b0;
      underrun_reg  <= 1'b0;
      pending_reg   <= 1'b0;
      next_q_reg    <= 1'b0;
    end else begin
      next_q_reg <= bus.next;

      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      end

      case ({push, pop})
        2'b10:   level_reg <= level_reg + ONE_L;
        2'b01:   level_reg <= level_reg - ONE_L;
        default: level_reg <= level_reg;
      endcase

      if (pop) begin
        {a_reg, b_reg} <= mem[rd_ptr_reg];
        rd_ptr_reg     <= rd_ptr_reg + PTR_ONE;
        remaining_reg  <= remaining_reg - ONE_L;
      end else if (start_ok) begin
        remaining_reg  <= bus.frame_len;
      end

      if (underrun_evt) begin
        pending_reg <= 1'b1;
      end else if (pop) begin
        pending_reg <= 1'b0;
      end

      if (underrun_evt) begin
        underrun_reg <= 1'b1;
      end

      if (bus.wr_en && full && !pop) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  assign bus.A        = a_reg;
  assign bus.B        = b_reg;
  assign bus.full     = full;
  assign bus.empty    = empty;
  assign bus.level    = level_reg;
  assign bus.overflow = overflow_reg;
  assign bus.underrun = underrun_reg;

endmodule

// File: tb/tb_sse_feeder.sv
// tb_sse_feeder -- scoreboard bench for sse_feeder.
// Every accepted write is appended to an expected-pair queue in write order;
// a monitor pops one entry each time the feeder presents a new pair (valid
// rising, or A/B changing while valid). Directed status checks cover reset,
// full/overflow, underrun/pending, edge detection, illegal frame lengths,
// mid-frame reset and pointer wrap with a frame restart.
module tb_sse_feeder;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  localparam logic [31:0] F_0P5 = 32'h3F000000;
  localparam logic [31:0] F_1   = 32'h3F800000;
  localparam logic [31:0] F_2   = 32'h40000000;
  localparam logic [31:0] F_3   = 32'h40400000;
  localparam logic [31:0] F_4   = 32'h40800000;
  localparam logic [31:0] F_5   = 32'h40A00000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sse_feeder_if #(.AW(AW)) bus ();

  sse_feeder #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          vectors = 0;
  int          errors  = 0;
  logic [63:0] exp_q[$];
  logic [63:0] mon_exp;
  logic        prev_valid = 1'b0;
  logic [63:0] prev_ab    = '0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end else begin
      $display("ok   %s: %h", name, got);
    end
  endtask

  // Monitor: one comparison per newly presented pair.
  always @(negedge clk) begin
    if (!rst && bus.valid && (!prev_valid || {bus.A, bus.B} != prev_ab)) begin
      if (exp_q.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL pair: got %h, no pair expected", {bus.A, bus.B});
      end else begin
        mon_exp = exp_q.pop_front();
        check("pair", {bus.A, bus.B}, mon_exp);
      end
    end
    prev_valid <= bus.valid;
    prev_ab    <= {bus.A, bus.B};
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b, input bit expect_it);
    bus.wr_en = 1'b1;
    bus.wr_a  = a;
    bus.wr_b  = b;
    step();
    bus.wr_en = 1'b0;
    if (expect_it) exp_q.push_back({a, b});
  endtask

  task automatic pulse_next();
    bus.next = 1'b1;
    step();
    bus.next = 1'b0;
    step();
  endtask

  task automatic start_frame(input int n);
    bus.start     = 1'b1;
    bus.frame_len = (AW+1)'(n);
    step();
    bus.start = 1'b0;
    step();
    step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic check_idle(input string tag);
    check({tag, " valid"},    64'(bus.valid),    64'd0);
    check({tag, " stop"},     64'(bus.stop),     64'd0);
    check({tag, " done"},     64'(bus.done),     64'd0);
    check({tag, " level"},    64'(bus.level),    64'd0);
    check({tag, " empty"},    64'(bus.empty),    64'd1);
    check({tag, " full"},     64'(bus.full),     64'd0);
    check({tag, " AB"},       {bus.A, bus.B},    64'd0);
    check({tag, " overflow"}, 64'(bus.overflow), 64'd0);
    check({tag, " underrun"}, 64'(bus.underrun), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.wr_en     = 1'b0;
    bus.wr_a      = '0;
    bus.wr_b      = '0;
    bus.start     = 1'b0;
    bus.frame_len = '0;
    bus.next      = 1'b0;
    idle(2);
    rst = 1'b0;
    check_idle("reset");

    // Three-pair frame, stop with the last pair, DONE on the third next.
    push(F_1, F_0P5, 1'b1);
    push(F_2, F_1,   1'b1);
    push(F_3, F_3,   1'b1);
    start_frame(3);
    check("f3 valid", 64'(bus.valid), 64'd1);
    check("f3 stop0", 64'(bus.stop),  64'd0);
    pulse_next();
    check("f3 stop1", 64'(bus.stop),  64'd0);
    pulse_next();
    check("f3 stop2", 64'(bus.stop),  64'd1);
    check("f3 done2", 64'(bus.done),  64'd0);
    pulse_next();
    check("f3 done",  64'(bus.done),  64'd1);
    check("f3 hold",  {bus.A, bus.B}, {F_3, F_3});
    pulse_next();
    check("f3 ignore next", 64'(bus.done), 64'd1);
    check("f3 underrun", 64'(bus.underrun), 64'd0);

    // Fill, overflow, simultaneous push/pop at full.
    do_reset();
    for (int i = 0; i < DEPTH; i++) push($urandom(), $urandom(), 1'b1);
    check("fill full",  64'(bus.full),  64'd1);
    check("fill level", 64'(bus.level), 64'(DEPTH));
    push($urandom(), $urandom(), 1'b0);
    check("ovf flag",  64'(bus.overflow), 64'd1);
    check("ovf level", 64'(bus.level),    64'(DEPTH));
    bus.start     = 1'b1;
    bus.frame_len = (AW+1)'(DEPTH);
    step();
    bus.start = 1'b0;
    push($urandom(), $urandom(), 1'b1);   // lands on the PRIME pop edge
    check("pushpop level", 64'(bus.level), 64'(DEPTH));
    check("pushpop full",  64'(bus.full),  64'd1);
    for (int i = 0; i < DEPTH - 1; i++) pulse_next();
    check("full frame stop", 64'(bus.stop), 64'd1);
    pulse_next();
    check("full frame done",  64'(bus.done),  64'd1);
    check("full frame level", 64'(bus.level), 64'd1);
    start_frame(1);
    check("len1 stop", 64'(bus.stop), 64'd1);
    check("len1 done", 64'(bus.done), 64'd0);
    pulse_next();
    check("len1 done2", 64'(bus.done), 64'd1);

    // Empty PRIME, late data, underrun with pending fetch.
    do_reset();
    bus.start     = 1'b1;
    bus.frame_len = (AW+1)'(2);
    step();
    bus.start = 1'b0;
    idle(2);
    check("prime valid", 64'(bus.valid), 64'd0);
    push(F_4, F_1, 1'b1);
    step();
    check("late pair", {bus.A, bus.B}, {F_4, F_1});
    check("late stop", 64'(bus.stop), 64'd0);
    pulse_next();
    check("underrun flag", 64'(bus.underrun), 64'd1);
    check("underrun hold", {bus.A, bus.B}, {F_4, F_1});
    push(F_5, F_2, 1'b1);
    step();
    check("pending pair", {bus.A, bus.B}, {F_5, F_2});
    check("pending stop", 64'(bus.stop), 64'd1);
    pulse_next();
    check("pending done", 64'(bus.done), 64'd1);

    // Held next counts once.
    do_reset();
    for (int i = 0; i < 3; i++) push($urandom(), $urandom(), 1'b1);
    start_frame(3);
    bus.next = 1'b1;
    idle(5);
    bus.next = 1'b0;
    step();
    check("held next level", 64'(bus.level), 64'd1);

    // Illegal frame lengths are ignored; length 1 still works.
    do_reset();
    start_frame(0);
    push($urandom(), $urandom(), 1'b1);
    idle(3);
    check("len0 valid", 64'(bus.valid), 64'd0);
    check("len0 level", 64'(bus.level), 64'd1);
    start_frame(DEPTH + 1);
    check("len17 valid", 64'(bus.valid), 64'd0);
    check("len17 level", 64'(bus.level), 64'd1);
    start_frame(1);
    check("len1b valid", 64'(bus.valid), 64'd1);
    pulse_next();
    check("len1b done", 64'(bus.done), 64'd1);

    // Reset mid-frame with five pairs queued.
    do_reset();
    for (int i = 0; i < 8; i++) push($urandom(), $urandom(), 1'b1);
    start_frame(8);
    pulse_next();
    pulse_next();
    check("mid level", 64'(bus.level), 64'd5);
    do_reset();
    check_idle("midrst");

    // 20 pairs through pointer wrap, frame of 16 then restart of 4.
    for (int i = 0; i < 12; i++) begin
      push($urandom(), $urandom(), 1'b1);
      idle($urandom_range(0, 2));
    end
    start_frame(16);
    for (int i = 0; i < 8; i++) begin
      pulse_next();
      idle($urandom_range(0, 3));
      push($urandom(), $urandom(), 1'b1);
      idle($urandom_range(0, 3));
    end
    for (int i = 0; i < 7; i++) begin
      pulse_next();
      idle($urandom_range(0, 2));
    end
    check("wrap stop", 64'(bus.stop), 64'd1);
    pulse_next();
    check("wrap done",  64'(bus.done),  64'd1);
    check("wrap level", 64'(bus.level), 64'd4);
    start_frame(4);
    for (int i = 0; i < 3; i++) pulse_next();
    check("restart stop", 64'(bus.stop), 64'd1);
    pulse_next();
    check("restart done",  64'(bus.done),  64'd1);
    check("restart empty", 64'(bus.empty), 64'd1);
    check("no underrun",   64'(bus.underrun), 64'd0);
    check("scoreboard drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
